// File: rtl/oled_cmd_sched_if.sv
// Bus/driver-side signal bundle for oled_cmd_sched.
// master = CPU store path plus SPI driver, slave = the scheduler; dbg_state exposes the FSM.
interface oled_cmd_sched_if;
  logic       wr_en;
  logic [9:0] wr_data;
  logic       clr_ovf;
  logic       spi_busy;
  logic       spi_start;
  logic [9:0] spi_din;
  logic [15:0] status;
  logic [2:0] dbg_state;

  modport master (
    output wr_en, wr_data, clr_ovf, spi_busy,
    input  spi_start, spi_din, status, dbg_state
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf, spi_busy,
    output spi_start, spi_din, status, dbg_state
  );
endinterface

// File: rtl/oled_cmd_sched.sv
// OLED command scheduler: entry FIFO, power-up sequence, one SPI start per entry.
// Optional OLED_DELAY_CMD_EN turns entries with bits[9:8]=2'b11 into timed waits.
module oled_cmd_sched #(
`ifdef OLED_DELAY_CMD_EN
  parameter int unsigned DELAY_UNIT  = 125000,
`endif
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PWR_DELAY   = 12500000,
  parameter int unsigned START_HOLD  = 2,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic clk_125mhz,
  input  logic reset,
  oled_cmd_sched_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    PWR_ON   = 3'd0,
    PWR_WAIT = 3'd1,
    IDLE     = 3'd2,
    START    = 3'd3,
    ACK      = 3'd4,
`ifdef OLED_DELAY_CMD_EN
    DONE     = 3'd5,
    DELAY    = 3'd6
`else
    DONE     = 3'd5
`endif
  } state_t;

  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          busy_q;
  state_t        state_q;
  logic [31:0]   cnt_q;
  logic          spi_start_q;
  logic [9:0]    spi_din_q;
`ifdef OLED_DELAY_CMD_EN
  logic [31:0]   delay_len_q;
`endif

  logic       full, empty, push, pop;
  logic [9:0] head;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign push  = bus.wr_en && !full;
  // The only dequeue point: IDLE hands the head to the driver (or to DELAY).
  assign pop   = (state_q == IDLE) && !empty && !bus.spi_busy;

  always_ff @(posedge clk_125mhz) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (bus.wr_en && full) ovf_q <= 1'b1;
      else if (bus.clr_ovf)  ovf_q <= 1'b0;
      // Registered so that status reads all-clear except empty straight out of reset.
      busy_q <= (state_q != IDLE) || !empty;
    end
  end

  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      state_q     <= PWR_ON;
      cnt_q       <= '0;
      spi_start_q <= 1'b0;
      spi_din_q   <= '0;
`ifdef OLED_DELAY_CMD_EN
      delay_len_q <= '0;
`endif
    end else begin
      case (state_q)
        PWR_ON: begin
          spi_din_q <= 10'h200;
          if (cnt_q >= START_HOLD) begin
            spi_start_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= PWR_WAIT;
          end else begin
            spi_start_q <= 1'b1;
            cnt_q       <= cnt_q + 1;
          end
        end
        PWR_WAIT: begin
          if (cnt_q + 1 >= PWR_DELAY) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1;
          end
        end
        IDLE: begin
          if (pop) begin
`ifdef OLED_DELAY_CMD_EN
            if (head[9:8] == 2'b11) begin
              delay_len_q <= 32'(head[7:0]) * DELAY_UNIT;
              cnt_q       <= '0;
              state_q     <= DELAY;
            end else begin
`else
            begin
`endif
              spi_din_q   <= head;
              spi_start_q <= 1'b1;
              cnt_q       <= 32'd1;
              state_q     <= START;
            end
          end
        end
        START: begin
          if (cnt_q >= START_HOLD) begin
            spi_start_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ACK;
          end else begin
            cnt_q <= cnt_q + 1;
          end
        end
        ACK: begin
          // Power entries never raise spi_busy, so the timeout is their normal exit.
          if (bus.spi_busy) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else if (cnt_q + 1 >= ACK_TIMEOUT) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1;
          end
        end
        DONE: begin
          if (!bus.spi_busy) state_q <= IDLE;
        end
`ifdef OLED_DELAY_CMD_EN
        DELAY: begin
          // A zero-length delay still costs one cycle here.
          if (cnt_q + 1 >= delay_len_q) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1;
          end
        end
`endif
        default: begin
          spi_start_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= PWR_ON;
        end
      endcase
    end
  end

  assign bus.spi_start = spi_start_q;
  assign bus.spi_din   = spi_din_q;
  assign bus.status    = {ovf_q, full, empty, busy_q, 7'b0, 5'(count_q)};
  assign bus.dbg_state = state_q;

endmodule
